// File: rtl/letter_sched_pkg.sv
// Shared definitions for the falling-letter scheduler: FSM encoding,
// slot-record field widths, and the difficulty-level helper that is used
// only when LETTER_SCHED_LEVEL_EN is defined.
package letter_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_SPAWN = 2'd2,
    ST_KEY   = 2'd3
  } state_t;

  localparam int CH_W  = 8;
  localparam int X_W   = 9;
  localparam int Y_W   = 10;
  localparam int SPD_W = 3;

  localparam int LEVEL_STEP  = 4;
  localparam int LEVEL_SHIFT = 4;
  localparam int LEVEL_FLOOR = 16;

  // A generator speed of zero would park a letter forever; promote it to 1.
  function automatic logic [SPD_W-1:0] clamp_speed(input logic [SPD_W-1:0] s);
    return (s == '0) ? SPD_W'(1) : s;
  endfunction

  // Spawn interval shrinks by LEVEL_STEP frames for every 16 hits, never
  // dropping below LEVEL_FLOOR.
  function automatic int level_interval(input int base, input logic [15:0] score);
    int iv;
    iv = base - LEVEL_STEP * int'(score >> LEVEL_SHIFT);
    if (iv < LEVEL_FLOOR) iv = LEVEL_FLOOR;
    return iv;
  endfunction

endpackage

// File: rtl/letter_scheduler_match.sv
// Key matcher: among active slots whose letter equals key_ch, picks the one
// lowest on screen (largest x); equal x resolves to the lowest slot index.
// Purely combinational.
module letter_match
  import letter_sched_pkg::*;
#(
  parameter int SLOTS = 8
) (
  input  logic [SLOTS-1:0]         active,
  input  logic [SLOTS*CH_W-1:0]    ch_vec,
  input  logic [SLOTS*X_W-1:0]     x_vec,
  input  logic [CH_W-1:0]          key_ch,
  output logic                     found,
  output logic [$clog2(SLOTS)-1:0] target_idx
);

  localparam int IDX_W = $clog2(SLOTS);

  logic [X_W-1:0] best_x;

  // Linear scan; strict '>' keeps the earlier (lower) index on ties.
  always_comb begin
    found      = 1'b0;
    target_idx = '0;
    best_x     = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (active[i] && (ch_vec[i*CH_W +: CH_W] == key_ch) &&
          (!found || (x_vec[i*X_W +: X_W] > best_x))) begin
        found      = 1'b1;
        target_idx = IDX_W'(i);
        best_x     = x_vec[i*X_W +: X_W];
      end
    end
  end

endmodule

// File: rtl/letter_scheduler.sv
// Falling-letter pool for the typing game. Each frame walks every slot
// (one per cycle) moving letters down and retiring misses, optionally spawns
// a letter, and services keypresses between frames.
// Optional feature macro: LETTER_SCHED_LEVEL_EN (score-driven spawn interval).
module letter_scheduler
  import letter_sched_pkg::*;
#(
  parameter int SLOTS          = 8,
  parameter int BOTTOM         = 480,
  parameter int SPAWN_INTERVAL = 60
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic [CH_W-1:0]          gen_ch,
  input  logic [SPD_W-1:0]         gen_speed,
  input  logic [Y_W-1:0]           gen_y,
  input  logic                     key_valid,
  input  logic [CH_W-1:0]          key_ch,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic                     rd_active,
  output logic [CH_W-1:0]          rd_ch,
  output logic [X_W-1:0]           rd_x,
  output logic [Y_W-1:0]           rd_y,
  output logic                     hit_pulse,
  output logic                     wrong_pulse,
  output logic                     miss_pulse,
  output logic [15:0]              score,
  output logic [7:0]               miss_count,
  output logic                     busy
);

  localparam int IDX_W = $clog2(SLOTS);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg;
  logic [15:0]        spawn_cnt_reg;
  logic               frame_pend_reg;
  logic               key_pend_reg;
  logic [CH_W-1:0]    key_ch_reg;
  logic [15:0]        score_reg;
  logic [7:0]         miss_count_reg;
  logic               hit_pulse_reg, wrong_pulse_reg, miss_pulse_reg;

  logic               slot_active_reg [SLOTS];
  logic [CH_W-1:0]    slot_ch_reg     [SLOTS];
  logic [X_W-1:0]     slot_x_reg      [SLOTS];
  logic [Y_W-1:0]     slot_y_reg      [SLOTS];
  logic [SPD_W-1:0]   slot_spd_reg    [SLOTS];

  logic [SLOTS-1:0]      active_vec;
  logic [SLOTS*CH_W-1:0] ch_vec;
  logic [SLOTS*X_W-1:0]  x_vec;

  logic               match_found;
  logic [IDX_W-1:0]   match_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [X_W:0]       move_sum;
  logic               move_retire;
  logic               last_slot;
  logic               spawn_due;
  logic               frame_req;
  logic               key_req;

  // Flatten the slot registers for the matcher.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_flat
    assign active_vec[gi]              = slot_active_reg[gi];
    assign ch_vec[gi*CH_W +: CH_W]     = slot_ch_reg[gi];
    assign x_vec[gi*X_W +: X_W]        = slot_x_reg[gi];
  end

  letter_match #(.SLOTS(SLOTS)) u_match (
    .active     (active_vec),
    .ch_vec     (ch_vec),
    .x_vec      (x_vec),
    .key_ch     (key_ch_reg),
    .found      (match_found),
    .target_idx (match_idx)
  );

  // Lowest-index free slot for spawning (descending scan leaves the lowest).
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_active_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign move_sum    = {1'b0, slot_x_reg[idx_reg]} + {{(X_W+1-SPD_W){1'b0}}, slot_spd_reg[idx_reg]};
  assign move_retire = move_sum >= (X_W+1)'(BOTTOM);
  assign last_slot   = (idx_reg == IDX_W'(SLOTS - 1));
  assign frame_req   = frame_tick | frame_pend_reg;
  assign key_req     = key_valid | key_pend_reg;

`ifdef LETTER_SCHED_LEVEL_EN
  // '>=' lets a lowered threshold trigger immediately if already passed.
  assign spawn_due = int'(spawn_cnt_reg) >= (level_interval(SPAWN_INTERVAL, score_reg) - 1);
`else
  assign spawn_due = (spawn_cnt_reg == 16'(SPAWN_INTERVAL - 1));
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: frame work outranks a waiting key.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (frame_req)    state_next = ST_MOVE;
        else if (key_req) state_next = ST_KEY;
      end
      ST_MOVE: begin
        if (last_slot) state_next = spawn_due ? ST_SPAWN : ST_IDLE;
      end
      ST_SPAWN: state_next = ST_IDLE;
      ST_KEY:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Slot pool, latches, counters and one-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg         <= '0;
      spawn_cnt_reg   <= '0;
      frame_pend_reg  <= 1'b0;
      key_pend_reg    <= 1'b0;
      key_ch_reg      <= '0;
      score_reg       <= '0;
      miss_count_reg  <= '0;
      hit_pulse_reg   <= 1'b0;
      wrong_pulse_reg <= 1'b0;
      miss_pulse_reg  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_active_reg[i] <= 1'b0;
        slot_ch_reg[i]     <= '0;
        slot_x_reg[i]      <= '0;
        slot_y_reg[i]      <= '0;
        slot_spd_reg[i]    <= '0;
      end
    end else begin
      hit_pulse_reg   <= 1'b0;
      wrong_pulse_reg <= 1'b0;
      miss_pulse_reg  <= 1'b0;

      // A tick seen in IDLE starts the frame directly; otherwise hold one.
      if (state_reg == ST_IDLE)
        frame_pend_reg <= 1'b0;
      else if (frame_tick)
        frame_pend_reg <= 1'b1;

      // The KEY cycle consumes the latch; a full latch drops new keys.
      if (state_reg == ST_KEY) begin
        key_pend_reg <= 1'b0;
      end else if (key_valid && !key_pend_reg) begin
        key_pend_reg <= 1'b1;
        key_ch_reg   <= key_ch;
      end

      unique case (state_reg)
        ST_IDLE: idx_reg <= '0;
        ST_MOVE: begin
          idx_reg <= idx_reg + 1'b1;
          if (slot_active_reg[idx_reg]) begin
            if (move_retire) begin
              slot_active_reg[idx_reg] <= 1'b0;
              miss_pulse_reg           <= 1'b1;
              if (miss_count_reg != 8'hFF) miss_count_reg <= miss_count_reg + 8'd1;
            end else begin
              slot_x_reg[idx_reg] <= move_sum[X_W-1:0];
            end
          end
          if (last_slot) begin
            if (spawn_due) spawn_cnt_reg <= '0;
            else           spawn_cnt_reg <= spawn_cnt_reg + 16'd1;
          end
        end
        ST_SPAWN: begin
          if (free_found) begin
            slot_active_reg[free_idx] <= 1'b1;
            slot_ch_reg[free_idx]     <= gen_ch;
            slot_x_reg[free_idx]      <= '0;
            slot_y_reg[free_idx]      <= gen_y;
            slot_spd_reg[free_idx]    <= clamp_speed(gen_speed);
          end
        end
        ST_KEY: begin
          if (match_found) begin
            slot_active_reg[match_idx] <= 1'b0;
            hit_pulse_reg              <= 1'b1;
            if (score_reg != 16'hFFFF) score_reg <= score_reg + 16'd1;
          end else begin
            wrong_pulse_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_active   = slot_active_reg[rd_idx];
  assign rd_ch       = slot_ch_reg[rd_idx];
  assign rd_x        = slot_x_reg[rd_idx];
  assign rd_y        = slot_y_reg[rd_idx];
  assign hit_pulse   = hit_pulse_reg;
  assign wrong_pulse = wrong_pulse_reg;
  assign miss_pulse  = miss_pulse_reg;
  assign score       = score_reg;
  assign miss_count  = miss_count_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule
